wt_fetch2: RTL and testbench

Read-side sequencer for the second-layer weight ROM (`wt_mem2`-style, dual read port, one-cycle registered read, 144-bit words). On `start` it walks a contiguous word range and drives both ROM ports in parallel: port A reads the even offsets and port B the odd offsets. It streams the fetched kernel words to the CNN conv engine over a valid/ready interface, with a 2-entry skid FIFO, so backpressure never drops or repeats a word.

---
 rtl/cnn_wt_pkg.sv | 21 ++
 rtl/wt_skid_fifo.sv | 59 +++++
 rtl/wt_fetch2.sv | 180 ++++++++++++++++++
 tb/tb_wt_fetch2.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_wt_pkg.sv
// Shared types for the CNN weight path: tap/kernel views of a ROM word and
// the state encoding of the layer-2 weight fetch sequencer.
package cnn_wt_pkg;

  localparam int TAP_WIDTH = 16;
  localparam int TAPS      = 9;

  // One signed filter tap; tap 0 sits in the least significant slice.
  typedef logic signed [TAP_WIDTH-1:0] tap_t;

  // A 3x3 kernel as packed taps, bit-compatible with one ROM word.
  typedef tap_t [TAPS-1:0] kernel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wt_fetch_state_e;

endpackage

// File: rtl/wt_skid_fifo.sv
// Two-entry FIFO with the head entry held in a register that drives the
// outputs directly. A push while full is only accepted together with a pop.
module wt_skid_fifo #(
  parameter int WIDTH = 290
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       count_reg;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  // Head/tail storage and occupancy; head is always the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= din;
          else                   tail_reg <= din;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) head_reg <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            head_reg <= din;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head_reg;
  assign valid = (count_reg != 2'd0);
  assign count = count_reg;

endmodule

// File: rtl/wt_fetch2.sv
// Read sequencer for the layer-2 weight ROM. Walks a word range two words per
// request (port A even offsets, port B odd offsets) and streams the pairs out
// through a small skid FIFO. Requests are credit-limited so that every word in
// flight always has a FIFO slot waiting for it.
module wt_fetch2
  import cnn_wt_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 144,
  parameter int TAP_WIDTH  = 16,
  parameter int TAPS       = 9,
  parameter int DEPTH      = 76
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rom_addr_a,
  output logic [ADDR_WIDTH-1:0] rom_addr_b,
  input  logic [DATA_WIDTH-1:0] rom_q_a,
  input  logic [DATA_WIDTH-1:0] rom_q_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_word_a,
  output logic [DATA_WIDTH-1:0] out_word_b,
  output logic                  out_b_valid,
  output logic                  out_last
);

  localparam int WORD_BITS = TAPS * TAP_WIDTH;
  localparam int PAY_BITS  = 2 * WORD_BITS + 2;
  localparam logic [ADDR_WIDTH+1:0] DEPTH_END = (ADDR_WIDTH+2)'(DEPTH);
  localparam logic [ADDR_WIDTH+1:0] EXT_ONE   = (ADDR_WIDTH+2)'(1);
  localparam logic [ADDR_WIDTH+1:0] EXT_TWO   = (ADDR_WIDTH+2)'(2);
  localparam logic [ADDR_WIDTH+1:0] EXT_THREE = (ADDR_WIDTH+2)'(3);

  wt_fetch_state_e state_reg;

  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] addr_a_reg;
  logic [ADDR_WIDTH-1:0] addr_b_reg;
  logic [ADDR_WIDTH:0]   num_reg;
  logic [ADDR_WIDTH:0]   ptr_reg;
  logic                  inflight_reg;
  logic                  tag_last_reg;
  logic                  tag_b_valid_reg;
  logic                  err_reg;

  logic [ADDR_WIDTH+1:0] range_end;
  logic [ADDR_WIDTH+1:0] ptr_ext;
  logic [ADDR_WIDTH+1:0] num_ext;
  logic [ADDR_WIDTH:0]   ptr_next;
  logic [ADDR_WIDTH-1:0] next_addr_a;
  logic                  pair_b_valid;
  logic                  pair_last;
  logic                  next_b_valid;
  logic [2:0]            occupancy;
  logic                  issue;
  logic                  pop;

  logic [PAY_BITS-1:0]   fifo_din;
  logic [PAY_BITS-1:0]   fifo_dout;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;

  // Range bookkeeping; widened by one bit so base+num cannot wrap.
  assign range_end    = {2'b00, base_addr} + {1'b0, num_words};
  assign ptr_ext      = {1'b0, ptr_reg};
  assign num_ext      = {1'b0, num_reg};
  assign ptr_next     = ptr_reg + (ADDR_WIDTH+1)'(2);
  assign next_addr_a  = base_reg + ptr_next[ADDR_WIDTH-1:0];
  assign pair_b_valid = (ptr_ext + EXT_ONE) < num_ext;
  assign pair_last    = (ptr_ext + EXT_TWO) >= num_ext;
  assign next_b_valid = (ptr_ext + EXT_THREE) < num_ext;

  // A pair may be requested only if a FIFO slot is guaranteed when it returns;
  // a pop in this cycle frees a slot in time.
  assign pop       = fifo_valid & out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg};
  assign issue     = (state_reg == ST_FETCH) && (occupancy < (3'd2 + {2'b00, pop}));

  // Sequencer: accepts/rejects starts, advances the pair pointer, and waits
  // for the stream to drain before signalling completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      base_reg   <= '0;
      num_reg    <= '0;
      ptr_reg    <= '0;
      addr_a_reg <= '0;
      addr_b_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (num_words == '0) begin
              state_reg <= ST_DONE;
            end else if (range_end > DEPTH_END) begin
              err_reg <= 1'b1;
            end else begin
              base_reg   <= base_addr;
              num_reg    <= num_words;
              ptr_reg    <= '0;
              addr_a_reg <= base_addr;
              addr_b_reg <= (num_words > (ADDR_WIDTH+1)'(1)) ?
                            base_addr + (ADDR_WIDTH)'(1) : base_addr;
              state_reg  <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            ptr_reg <= ptr_next;
            if (pair_last) begin
              state_reg <= ST_DRAIN;
            end else begin
              addr_a_reg <= next_addr_a;
              addr_b_reg <= next_b_valid ? next_addr_a + (ADDR_WIDTH)'(1) : next_addr_a;
            end
          end
        end
        ST_DRAIN: begin
          if (!inflight_reg && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
            state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Tracks the pair currently inside the ROM pipeline and its beat tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_reg    <= 1'b0;
      tag_last_reg    <= 1'b0;
      tag_b_valid_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        tag_last_reg    <= pair_last;
        tag_b_valid_reg <= pair_b_valid;
      end
    end
  end

  // Port B data of a lone tail word is a duplicate read and is zeroed here.
  assign fifo_din = {tag_last_reg, tag_b_valid_reg,
                     (tag_b_valid_reg ? rom_q_b : '0), rom_q_a};

  wt_skid_fifo #(
    .WIDTH (PAY_BITS)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_reg),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign rom_addr_a  = addr_a_reg;
  assign rom_addr_b  = addr_b_reg;
  assign out_valid   = fifo_valid;
  assign out_word_a  = fifo_dout[WORD_BITS-1:0];
  assign out_word_b  = fifo_dout[2*WORD_BITS-1:WORD_BITS];
  assign out_b_valid = fifo_dout[2*WORD_BITS];
  assign out_last    = fifo_dout[2*WORD_BITS+1];
  assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
  assign done        = (state_reg == ST_DONE);
  assign err         = err_reg;

endmodule

// File: tb/tb_wt_fetch2.sv
// Randomized bench for wt_fetch2: a behavioural ROM with registered read,
// an expected-beat queue built from the range rules, and per-cycle checks of
// ordering, holding under backpressure, latency, rate and done timing.
module tb_wt_fetch2;

  localparam int AW    = 11;
  localparam int DW    = 144;
  localparam int DEPTH = 76;

  typedef logic [299:0] cv_t;
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          bv;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy, done, err;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [DW-1:0] rom_q_a, rom_q_b;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_word_a, out_word_b;
  logic          out_b_valid, out_last;

  logic [DW-1:0] rom [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // ROM model: one-cycle registered read on both ports.
  always @(posedge clk) begin
    rom_q_a <= (int'(rom_addr_a) < DEPTH) ? rom[rom_addr_a] : '0;
    rom_q_b <= (int'(rom_addr_b) < DEPTH) ? rom[rom_addr_b] : '0;
  end

  wt_fetch2 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rom_addr_a  (rom_addr_a),
    .rom_addr_b  (rom_addr_b),
    .rom_q_a     (rom_q_a),
    .rom_q_b     (rom_q_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_word_a  (out_word_a),
    .out_word_b  (out_word_b),
    .out_b_valid (out_b_valid),
    .out_last    (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input cv_t got, input cv_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  cv_t'(busy),        cv_t'(0));
    check({tag, "_done"},  cv_t'(done),        cv_t'(0));
    check({tag, "_err"},   cv_t'(err),         cv_t'(0));
    check({tag, "_valid"}, cv_t'(out_valid),   cv_t'(0));
    check({tag, "_bv"},    cv_t'(out_b_valid), cv_t'(0));
    check({tag, "_last"},  cv_t'(out_last),    cv_t'(0));
    check({tag, "_wa"},    cv_t'(out_word_a),  cv_t'(0));
    check({tag, "_wb"},    cv_t'(out_word_b),  cv_t'(0));
    check({tag, "_ra"},    cv_t'(rom_addr_a),  cv_t'(0));
    check({tag, "_rb"},    cv_t'(rom_addr_b),  cv_t'(0));
  endtask

  // ready_mode: 0 always ready, 1 random, 2 stalled on cycles 3..7.
  task automatic run_range(input int base, input int num, input int ready_mode, input bit poke);
    beat_t exp_q[$];
    beat_t bt;
    int    cyc, beats, last_hs, prev_hs;
    bit    done_seen, hold;
    cv_t   held;

    start     = 1'b1;
    base_addr = AW'(base);
    num_words = (AW+1)'(num);
    tick();
    start = 1'b0;

    if (num == 0) begin
      check("zero_done",  cv_t'(done),      cv_t'(1));
      check("zero_busy",  cv_t'(busy),      cv_t'(0));
      check("zero_valid", cv_t'(out_valid), cv_t'(0));
      tick();
      check("zero_done_once", cv_t'(done), cv_t'(0));
      $display("[TB] range base=%0d num=%0d -> empty", base, num);
      return;
    end
    if (base + num > DEPTH) begin
      check("range_err",  cv_t'(err),  cv_t'(1));
      check("range_busy", cv_t'(busy), cv_t'(0));
      tick();
      check("range_err_once", cv_t'(err),  cv_t'(0));
      check("range_busy2",    cv_t'(busy), cv_t'(0));
      $display("[TB] range base=%0d num=%0d -> rejected", base, num);
      return;
    end

    for (int w = 0; w < num; w += 2) begin
      beat_t nb;
      nb.a    = rom[base + w];
      nb.bv   = (w + 1 < num);
      nb.b    = nb.bv ? rom[base + w + 1] : '0;
      nb.last = (w + 2 >= num);
      exp_q.push_back(nb);
    end

    check("busy_after_start", cv_t'(busy), cv_t'(1));
    cyc = 0; beats = 0; last_hs = -10; prev_hs = -10;
    done_seen = 1'b0; hold = 1'b0; held = '0;

    while (cyc < 400) begin
      if (done) begin
        done_seen = 1'b1;
        check("done_timing", cv_t'(cyc),          cv_t'(last_hs + 1));
        check("beats_all",   cv_t'(exp_q.size()), cv_t'(0));
        check("done_busy",   cv_t'(busy),         cv_t'(0));
        break;
      end
      check("no_err_busy", cv_t'(err), cv_t'(0));
      if (hold) begin
        check("hold_valid", cv_t'(out_valid), cv_t'(1));
        check("hold_beat",  cv_t'({out_last, out_b_valid, out_word_b, out_word_a}), held);
      end
      if (out_valid && beats == 0 && !hold)
        check("first_latency", cv_t'(cyc), cv_t'(2));

      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(cyc >= 3 && cyc <= 7);
      endcase
      if (poke) begin
        start     = (cyc == 4);
        base_addr = '0;
        num_words = (AW+1)'(2);
      end

      hold = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", cv_t'(1), cv_t'(0));
        end else begin
          bt = exp_q.pop_front();
          check("word_a",  cv_t'(out_word_a),  cv_t'(bt.a));
          check("word_b",  cv_t'(out_word_b),  cv_t'(bt.b));
          check("b_valid", cv_t'(out_b_valid), cv_t'(bt.bv));
          check("last",    cv_t'(out_last),    cv_t'(bt.last));
        end
        if (ready_mode == 0 && beats > 0)
          check("full_rate", cv_t'(cyc), cv_t'(prev_hs + 1));
        beats++;
        prev_hs = cyc;
        last_hs = cyc;
      end else if (out_valid) begin
        hold = 1'b1;
        held = cv_t'({out_last, out_b_valid, out_word_b, out_word_a});
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (!done_seen) check("done_timeout", cv_t'(0), cv_t'(1));
    out_ready = 1'b1;
    tick();
    check("done_once",   cv_t'(done),      cv_t'(0));
    check("idle_valid",  cv_t'(out_valid), cv_t'(0));
    $display("[TB] range base=%0d num=%0d -> %0d beats", base, num, beats);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, n;
    for (int i = 0; i < DEPTH; i++)
      for (int t = 0; t < 9; t++)
        rom[i][16*t +: 16] = 16'($urandom);

    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    check_all_zero("reset");

    run_range(0, 2, 0, 1'b0);
    run_range(74, 1, 0, 1'b0);
    run_range(75, 2, 0, 1'b0);
    run_range(0, 0, 0, 1'b0);
    run_range(75, 1, 1, 1'b0);
    run_range(0, 8, 2, 1'b1);
    run_range(0, 76, 0, 1'b0);
    run_range(1, 76, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, DEPTH - b));
      run_range(b, n, 1, k[0]);
    end
    b = int'($urandom_range(40, DEPTH - 1));
    run_range(b, DEPTH - b + 1 + int'($urandom_range(0, 5)), 1, 1'b0);

    // Reset in the middle of a 20-word run, during the second beat.
    start = 1'b1; base_addr = '0; num_words = (AW+1)'(20); out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_all_zero("midreset");
    for (int c = 0; c < 30; c++) begin
      check("midreset_no_done",  cv_t'(done),      cv_t'(0));
      check("midreset_no_valid", cv_t'(out_valid), cv_t'(0));
      tick();
    end
    $display("[TB] range base=0 num=20 -> abandoned by reset");

    run_range(10, 5, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
